// File: rtl/apb_arb_pkg.sv
// Shared FSM state type and default widths for the two-requester APB RAM arbiter.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package apb_arb_pkg;

    localparam int DEF_ADDR_W  = 12;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_t;

endpackage

// File: rtl/apb_rr_pick.sv
// Two-way round-robin pick with the last-grant register; requester 0 wins the first contention.
// Latency: combinational pick, last_gnt updates on the grant edge.
// Backpressure: grant is only recorded when take is high.
module apb_rr_pick (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt_vld,
    output logic       gnt_idx
);

    logic last_gnt;

    always_comb begin
        gnt_vld = |req;
        gnt_idx = req[1];
        if (req == 2'b11) begin
            gnt_idx = ~last_gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
        end else if (take && gnt_vld) begin
            last_gnt <= gnt_idx;
        end
    end

endmodule

// File: rtl/apb_ram_arbiter.sv
// Arbitrates two requesters onto one APB master port; ARB_TIMEOUT_EN adds an ACCESS watchdog.
// Latency: grant edge -> SETUP -> ACCESS; m_done registered one cycle after PREADY is sampled.
// Backpressure: requesters hold m_req until their m_done; ACCESS waits on PREADY.
module apb_ram_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic [1:0]          m_req,
    input  logic [1:0]          m_we,
    input  logic [2*ADDR_W-1:0] m_addr,
    input  logic [2*DATA_W-1:0] m_wdata,
    output logic [DATA_W-1:0]   m_rdata,
    output logic [1:0]          m_done,
    output logic                m_err,
    output logic [ADDR_W-1:0]   PADDR,
    output logic                PWRITE,
    output logic                PENABLE,
    output logic [DATA_W-1:0]   PWDATA,
    output logic                PSEL,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY
);

    arb_state_t          state;
    logic [1:0]          elig;
    logic                gnt_vld;
    logic                gnt_idx;
    logic                cur_gnt;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    // The requester finishing this cycle still has m_req up; keep it out of the next pick.
    assign elig = (state == IDLE) ? (m_req & ~m_done) : 2'b00;

    apb_rr_pick u_pick (
        .clk     (PCLK),
        .rst_n   (PRESET),
        .req     (elig),
        .take    (state == IDLE),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    assign sel_we    = m_we[gnt_idx];
    assign sel_addr  = gnt_idx ? m_addr[2*ADDR_W-1:ADDR_W]  : m_addr[ADDR_W-1:0];
    assign sel_wdata = gnt_idx ? m_wdata[2*DATA_W-1:DATA_W] : m_wdata[DATA_W-1:0];

`ifdef ARB_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] to_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign m_err          = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            state   <= IDLE;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
            m_rdata <= '0;
            m_done  <= 2'b00;
            cur_gnt <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            m_err   <= 1'b0;
            to_cnt  <= '0;
`endif
        end else begin
            m_done <= 2'b00;
`ifdef ARB_TIMEOUT_EN
            m_err  <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        state   <= SETUP;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        PWRITE  <= sel_we;
                        PADDR   <= sel_addr;
                        PWDATA  <= sel_wdata;
                        cur_gnt <= gnt_idx;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                    to_cnt  <= '0;
`endif
                end
                ACCESS: begin
                    if (PREADY) begin
                        state           <= IDLE;
                        PSEL            <= 1'b0;
                        PENABLE         <= 1'b0;
                        m_done[cur_gnt] <= 1'b1;
                        if (!PWRITE) begin
                            m_rdata <= PRDATA;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (to_cnt == CNT_LAST) begin
                        state           <= IDLE;
                        PSEL            <= 1'b0;
                        PENABLE         <= 1'b0;
                        m_done[cur_gnt] <= 1'b1;
                        m_err           <= 1'b1;
                        m_rdata         <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_ram_arbiter.sv
// Bench for apb_ram_arbiter: RAM slave with programmable wait states, per-requester scoreboards.
module tb_apb_ram_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic                PCLK = 1'b0;
    logic                PRESET;
    logic [1:0]          m_req;
    logic [1:0]          m_we;
    logic [2*ADDR_W-1:0] m_addr;
    logic [2*DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0]   m_rdata;
    logic [1:0]          m_done;
    logic                m_err;
    logic [ADDR_W-1:0]   PADDR;
    logic                PWRITE;
    logic                PENABLE;
    logic [DATA_W-1:0]   PWDATA;
    logic                PSEL;
    logic [DATA_W-1:0]   PRDATA;
    logic                PREADY;

    int checks   = 0;
    int failures = 0;

    always #5 PCLK = ~PCLK;

    apb_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16)) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_done  (m_done),
        .m_err   (m_err),
        .PADDR   (PADDR),
        .PWRITE  (PWRITE),
        .PENABLE (PENABLE),
        .PWDATA  (PWDATA),
        .PSEL    (PSEL),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY)
    );

    // RAM slave: PREADY after wait_n stalled ACCESS cycles; random PREADY outside ACCESS.
    logic [DATA_W-1:0] mem [0:255];
    int   wait_n  = 1;
    int   acc_cnt = 0;
    logic noise   = 1'b0;

    assign PRDATA = mem[PADDR[7:0]];
    assign PREADY = (PSEL && PENABLE) ? (acc_cnt >= wait_n) : noise;

    always @(posedge PCLK) begin
        noise <= 1'($urandom_range(0, 1));
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[7:0]] <= PWDATA;
    end

    typedef struct packed {
        logic              rd;
        logic              err;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              q0[$];
    exp_t              q1[$];
    logic [DATA_W-1:0] mdl_mem [0:255];
    bit                mdl_wr  [0:255];
    int                act_order[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int i, input logic we, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input logic err);
        exp_t e;
        e.rd   = !we;
        e.err  = err;
        e.data = '0;
        if (!err) begin
            if (we) begin
                mdl_mem[a[7:0]] = d;
                mdl_wr[a[7:0]]  = 1'b1;
            end else begin
                e.data = mdl_mem[a[7:0]];
            end
        end
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Monitor: every completion pulse is matched against the requester's oldest expectation.
    exp_t              mon_e;
    int                mon_idx;
    logic [DATA_W-1:0] mon_prev = '0;
    logic [DATA_W-1:0] mon_exp;

    always @(negedge PCLK) begin
        if (m_done != 2'b00) begin
            chk("done_onehot", 64'(m_done == 2'b01 || m_done == 2'b10), 64'(1));
            chk("done_apb_idle", 64'(PSEL), 64'(0));
            mon_idx = m_done[1] ? 1 : 0;
            act_order.push_back(mon_idx);
            if ((mon_idx == 0 ? q0.size() : q1.size()) == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: requester %0d got 0 outstanding, expected at least 1", mon_idx);
            end else begin
                if (mon_idx == 0) mon_e = q0.pop_front();
                else              mon_e = q1.pop_front();
                chk("done_err", 64'(m_err), 64'(mon_e.err));
                mon_exp = mon_e.err ? '0 : (mon_e.rd ? mon_e.data : mon_prev);
                chk("done_rdata", 64'(m_rdata), 64'(mon_exp));
                mon_prev = mon_exp;
            end
        end
        if (!PRESET) begin
            q0.delete();
            q1.delete();
            mon_prev = '0;
        end
    end

    // APB protocol: SETUP and a stalled ACCESS must be followed by ACCESS with frozen fields.
    logic              pp_rst = 1'b0, pp_sel = 1'b0, pp_en = 1'b0, pp_rdy = 1'b0, pp_we = 1'b0;
    logic [ADDR_W-1:0] pp_addr = '0;
    logic [DATA_W-1:0] pp_wd = '0;

    always @(negedge PCLK) begin
        if (pp_rst && pp_sel && !(pp_en && pp_rdy) && !(m_done != 2'b00 && m_err)) begin
            chk("apb_access", 64'({PSEL, PENABLE}), 64'(2'b11));
            chk("apb_addr_stable", 64'(PADDR), 64'(pp_addr));
            chk("apb_ctl_stable", 64'({PWRITE, PWDATA}), 64'({pp_we, pp_wd}));
        end
        chk("penable_needs_psel", 64'(PENABLE & ~PSEL), 64'(0));
        pp_rst  = PRESET;
        pp_sel  = PSEL;
        pp_en   = PENABLE;
        pp_rdy  = PREADY;
        pp_we   = PWRITE;
        pp_addr = PADDR;
        pp_wd   = PWDATA;
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic r, input logic we,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        m_req[i]                      = r;
        m_we[i]                       = we;
        m_addr[ADDR_W*i +: ADDR_W]    = a;
        m_wdata[DATA_W*i +: DATA_W]   = d;
    endtask

    task automatic xfer_single(input int i, input logic we, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d, input logic err, input int exp_lat,
                               input bit scramble, input string name);
        int lat = 0;
        set_req(i, 1'b1, we, a, d);
        push_exp(i, we, a, d, err);
        while (lat < 200) begin
            tick();
            lat++;
            if (lat == 1) begin
                chk({name, "_setup"}, 64'({PSEL, PENABLE}), 64'(2'b10));
                chk({name, "_paddr"}, 64'(PADDR), 64'(a));
                if (scramble) set_req(i, 1'b0, ~we, ~a, ~d);
            end
            if (lat == 2) chk({name, "_access"}, 64'({PSEL, PENABLE}), 64'(2'b11));
            if (m_done[i]) break;
        end
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        set_req(i, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic run_traffic(input int n0, input int n1, input int max_gap, input bit rnd_wait);
        int                left[2];
        int                gap[2];
        bit                busy[2];
        int                cyc = 0;
        logic              we;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        left[0] = n0;
        left[1] = n1;
        gap     = '{0, 0};
        busy    = '{0, 0};
        while ((left[0] + left[1] > 0 || busy[0] || busy[1]) && cyc < 20000) begin
            for (int i = 0; i < 2; i++) begin
                if (busy[i] && m_done[i]) begin
                    busy[i]  = 1'b0;
                    m_req[i] = 1'b0;
                    gap[i]   = $urandom_range(0, max_gap);
                end
                if (!busy[i] && left[i] > 0) begin
                    if (gap[i] > 0) begin
                        gap[i]--;
                    end else begin
                        we = 1'($urandom_range(0, 1));
                        a  = ADDR_W'(i * 128 + $urandom_range(0, 127));
                        if (!we && !mdl_wr[a[7:0]]) we = 1'b1;
                        d  = $urandom;
                        set_req(i, 1'b1, we, a, d);
                        push_exp(i, we, a, d, 1'b0);
                        busy[i] = 1'b1;
                        left[i]--;
                    end
                end
            end
            if (rnd_wait) wait_n = $urandom_range(0, 3);
            tick();
            cyc++;
        end
        chk("traffic_drained", 64'(cyc < 20000), 64'(1));
        m_req = 2'b00;
    endtask

    initial begin
        int base;
        int n;
        PRESET  = 1'b0;
        m_req   = '0;
        m_we    = '0;
        m_addr  = '0;
        m_wdata = '0;
        repeat (3) tick();
        chk("rst_apb_ctl", 64'({PSEL, PENABLE, PWRITE}), 64'(3'b000));
        chk("rst_paddr", 64'(PADDR), 64'(0));
        chk("rst_pwdata", 64'(PWDATA), 64'(0));
        chk("rst_done", 64'(m_done), 64'(0));
        chk("rst_err", 64'(m_err), 64'(0));
        chk("rst_rdata", 64'(m_rdata), 64'(0));
        PRESET = 1'b1;
        tick();

        xfer_single(0, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0, 4, 1'b0, "wr010");
        tick();
        xfer_single(0, 1'b0, 12'h010, 32'h0, 1'b0, 4, 1'b0, "rd010");
        chk("rd010_rdata", 64'(m_rdata), 64'(32'hDEADBEEF));
        chk("rd010_err", 64'(m_err), 64'(0));

        tick();
        wait_n = 5;
        xfer_single(1, 1'b1, 12'h090, 32'h1234_5678, 1'b0, 8, 1'b0, "stall");
        wait_n = 1;

        tick();
        xfer_single(0, 1'b0, 12'h010, 32'h0, 1'b0, 4, 1'b1, "late_change");

`ifdef ARB_TIMEOUT_EN
        tick();
        wait_n = 100000;
        xfer_single(1, 1'b0, 12'h090, 32'h0, 1'b1, 18, 1'b0, "timeout");
        chk("timeout_err", 64'(m_err), 64'(1));
        chk("timeout_rdata", 64'(m_rdata), 64'(0));
        wait_n = 1;
        tick();
        xfer_single(1, 1'b0, 12'h090, 32'h0, 1'b0, 4, 1'b0, "after_timeout");
        chk("after_timeout_rdata", 64'(m_rdata), 64'(32'h1234_5678));
`endif

        // Reset while a read sits in ACCESS.
        tick();
        wait_n = 100000;
        set_req(0, 1'b1, 1'b0, 12'h010, 32'h0);
        push_exp(0, 1'b0, 12'h010, 32'h0, 1'b0);
        tick();
        tick();
        chk("abort_in_access", 64'({PSEL, PENABLE}), 64'(2'b11));
        PRESET = 1'b0;
        set_req(0, 1'b0, 1'b0, '0, '0);
        tick();
        chk("abort_apb_idle", 64'({PSEL, PENABLE}), 64'(0));
        chk("abort_done", 64'(m_done), 64'(0));
        chk("abort_rdata", 64'(m_rdata), 64'(0));
        PRESET = 1'b1;
        wait_n = 1;
        n = 0;
        repeat (8) begin
            tick();
            if (m_done != 2'b00) n++;
        end
        chk("abort_no_late_done", 64'(n), 64'(0));

        // Fresh reset leaves requester 0 first; saturated requests must alternate.
        base = act_order.size();
        run_traffic(3, 3, 0, 1'b0);
        if (act_order.size() < base + 6) begin
            checks++;
            failures++;
            $display("FAIL alt_count: got %0d completions expected 6", act_order.size() - base);
        end else begin
            for (int k = 0; k < 6; k++) chk($sformatf("alt_order_%0d", k), 64'(act_order[base + k]), 64'(k % 2));
        end

        run_traffic(150, 150, 2, 1'b1);
        repeat (5) tick();
        chk("scoreboard_empty", 64'(q0.size() + q1.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: still running at %0t, expected finish well before", $time);
        $fatal(1);
    end

endmodule

// File: doc/apb_ram_arbiter.md
APB_RAM_ARBITER -- requirements
Module: apb_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, APB/requester address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, ACCESS-state cycle limit (used only under ARB_TIMEOUT_EN).
REQ-004 SHALL have port PCLK  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port PRESET  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port m_req  input  2  per-requester transfer request, bit i = requester i.
REQ-007 SHALL have port m_we  input  2  per-requester write(1)/read(0).
REQ-008 SHALL have port m_addr  input  2*ADDR_W  packed; requester i at [ADDR_W*i +: ADDR_W].
REQ-009 SHALL have port m_wdata  input  2*DATA_W  packed; requester i at [DATA_W*i +: DATA_W].
REQ-010 SHALL have port m_rdata  output  DATA_W  read data, valid only while a m_done bit is high.
REQ-011 SHALL have port m_done  output  2  one-cycle completion pulse, bit i = requester i.
REQ-012 SHALL have port m_err  output  1  error flag, valid with m_done.
REQ-013 SHALL have ports PADDR  output  ADDR_W, PWRITE  output  1, PENABLE  output  1, PWDATA  output  DATA_W, PSEL  output  1: APB master outputs to the RAM slave.
REQ-014 SHALL have ports PRDATA  input  DATA_W and PREADY  input  1: APB slave responses.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-016 IDLE: PSEL=0, PENABLE=0; if any eligible m_req bit is high, grant one requester, latch its we/addr/wdata into PWRITE/PADDR/PWDATA, go to SETUP.
REQ-017 Eligibility: in the IDLE cycle carrying a m_done pulse, the just-completed requester's m_req bit is masked.
REQ-018 Grant: single eligible request wins; both eligible -> requester != last_gnt wins (round-robin); last_gnt updates on every grant.
REQ-019 SETUP: PSEL=1, PENABLE=0, one cycle, then unconditionally ACCESS.
REQ-020 ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable; stay until PREADY=1 is sampled.
REQ-021 On PREADY=1 in ACCESS: register PRDATA into m_rdata (reads only; writes leave m_rdata unchanged), pulse the granted m_done bit for exactly one cycle with m_err=0, go to IDLE.
REQ-022 PREADY SHALL be ignored in IDLE and SETUP.
REQ-023 Requester inputs SHALL be sampled only at the grant edge; later changes do not affect the transfer.
REQ-024 Against the single-wait-state RAM slave: req high in IDLE -> m_done high 4 cycles later; back-to-back transfers with no idle gap beyond the done cycle.

Reset
REQ-025 While PRESET=0 at a clock edge: state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, m_rdata=0, m_done=0, m_err=0, last_gnt=1 (requester 0 wins the first contention), timeout counter=0.
REQ-026 Reset asserted mid-transfer SHALL abort it: no m_done pulse for the aborted transfer; APB idle on the next cycle.

Configuration
REQ-027 With ARB_TIMEOUT_EN defined: a counter clears on entering ACCESS and increments each ACCESS cycle without PREADY; at TIMEOUT cycles the FSM ends the transfer, pulses the granted m_done with m_err=1 and m_rdata=0, and returns to IDLE.
REQ-028 Without ARB_TIMEOUT_EN: no counter; ACCESS waits indefinitely; m_err tied to 0.

Structure
REQ-029 Package apb_arb_pkg SHALL hold the FSM state enum (IDLE/SETUP/ACCESS) and default ADDR_W/DATA_W/TIMEOUT constants.
REQ-030 Sub-module apb_rr_pick SHALL contain the 2-way round-robin selection and the last_gnt register; FSM and APB drive stay in apb_ram_arbiter.

Verification
REQ-031 Requester 0 writes 0xDEADBEEF to 0x010, then reads 0x010 -> PSEL/PENABLE sequence SETUP then ACCESS; read m_done[0] with m_rdata=0xDEADBEEF, m_err=0.
REQ-032 Both m_req bits rise in the same cycle after reset -> requester 0 granted first, requester 1 next; m_done[0] precedes m_done[1].
REQ-033 Both requesters held high for 6 transfers -> grants alternate 0,1,0,1,0,1; each m_done bit pulses once per transfer.
REQ-034 PREADY held low by a stub slave for 5 cycles -> PSEL/PENABLE/PADDR stable throughout; m_done fires 1 cycle after PREADY is finally sampled high.
REQ-035 PRESET driven low during ACCESS -> PSEL=0 and m_done=0 on the next cycle; no pending completion after reset release.
REQ-036 With ARB_TIMEOUT_EN and TIMEOUT=16, PREADY stuck low -> m_done pulses after 16 ACCESS cycles with m_err=1, m_rdata=0; the next request proceeds normally.
